// File: rtl/sipo_rx.sv
// ---------------------------------------------------------------------------
// sipo_rx
//
// Serial-in, parallel-out receiver. It rebuilds WIDTH-bit words from an
// LSB-first serial stream, taking one bit on every clock edge where sh is
// high. This is the receive end of the parallel-load / shift-out link.
//
// A completed word is shown on 'out' and held until the next word
// completes. Each completion gives a one-cycle 'valid' strobe. If sh drops
// while a frame is only partly received, the partial frame is discarded and
// 'abort' pulses for one cycle.
//
// Parameters:
//   WIDTH  word width in bits (2..32)
//   CW     bit-counter width, $clog2(WIDTH) (derived)
//
// Ports:
//   clk    in   clock; all state changes on the rising edge
//   reset  in   synchronous active-high reset, highest priority
//   sh     in   shift enable; 1 = sample sin on this edge
//   sin    in   serial data, LSB of each word first
//   out    out  [WIDTH-1:0] last completed word (held)
//   valid  out  one-cycle pulse: out was updated on this edge
//   abort  out  one-cycle pulse: a partial frame was discarded
//   cnt    out  [CW-1:0] bits received so far in the current frame
// ---------------------------------------------------------------------------
module sipo_rx #(
  parameter  int WIDTH = 4,
  localparam int CW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sh,
  input  logic             sin,
  output logic [WIDTH-1:0] out,
  output logic             valid,
  output logic             abort,
  output logic [CW-1:0]    cnt
);

  // IDLE means no bits of the current frame have been taken yet (cnt == 0).
  // RECV means a frame is partly received (0 < cnt < WIDTH).
  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

  // Counter value at which the next sampled bit completes the word.
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           state, state_nx;
  logic [WIDTH-1:0] sr, sr_nx;
  logic [WIDTH-1:0] out_nx;
  logic [CW-1:0]    cnt_nx;
  logic             valid_nx, abort_nx;
  logic [WIDTH-1:0] shifted;

  // Shift right and insert the new bit at the MSB. After WIDTH samples the
  // first bit received ends up at bit 0. The shift is written over the
  // concatenation and then truncated, so every bit of sr is read by
  // the logic.
  assign shifted = WIDTH'({sin, sr} >> 1);

  // Next-state logic. Every next value starts from "hold", and the pulses
  // start from 0. Only the branches below change them, so valid and abort
  // each last exactly one cycle. They are never both set at once because
  // they come from the sh=1 and sh=0 branches respectively.
  always_comb begin
    state_nx = state;
    sr_nx    = sr;
    cnt_nx   = cnt;
    out_nx   = out;
    valid_nx = 1'b0;
    abort_nx = 1'b0;

    if (sh) begin
      if (cnt == LAST_BIT) begin
        // The final bit goes straight to the output word. The shift
        // register is cleared so the next frame can start on the very
        // next edge.
        out_nx   = shifted;
        valid_nx = 1'b1;
        sr_nx    = '0;
        cnt_nx   = '0;
        state_nx = IDLE;
      end else begin
        sr_nx    = shifted;
        cnt_nx   = cnt + CW'(1);
        state_nx = RECV;
      end
    end else if (state == RECV) begin
      // sh dropped in the middle of a frame, so throw away what was
      // collected. 'out' keeps the last good word.
      abort_nx = 1'b1;
      sr_nx    = '0;
      cnt_nx   = '0;
      state_nx = IDLE;
    end
  end

  // State and output registers. Reset clears everything and has priority
  // over all other inputs. A frame cut off by reset is dropped without
  // raising abort.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      sr    <= '0;
      cnt   <= '0;
      out   <= '0;
      valid <= 1'b0;
      abort <= 1'b0;
    end else begin
      state <= state_nx;
      sr    <= sr_nx;
      cnt   <= cnt_nx;
      out   <= out_nx;
      valid <= valid_nx;
      abort <= abort_nx;
    end
  end

endmodule

// File: tb/tb_sipo_rx.sv
// ---------------------------------------------------------------------------
// tb_sipo_rx
//
// Self-checking bench for sipo_rx with WIDTH=4. The reference model keeps
// the bits of the current frame in a queue. It rebuilds each word
// arithmetically when the frame completes and compares the DUT outputs
// after every clock edge.
// ---------------------------------------------------------------------------
module tb_sipo_rx;

  localparam int WIDTH = 4;
  localparam int CW    = $clog2(WIDTH);

  logic             clk;
  logic             reset;
  logic             sh;
  logic             sin;
  logic [WIDTH-1:0] out;
  logic             valid;
  logic             abort;
  logic [CW-1:0]    cnt;

  int tests    = 0;
  int failures = 0;

  // Reference model state.
  int               frameBits[$];
  logic [WIDTH-1:0] expOut;
  logic             expValid;
  logic             expAbort;
  logic [CW-1:0]    expCnt;

  sipo_rx #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .sh    (sh),
    .sin   (sin),
    .out   (out),
    .valid (valid),
    .abort (abort),
    .cnt   (cnt)
  );

  // Free-running clock with a 10-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance the reference model by one rising edge.
  task automatic modelStep(input logic r, input logic s, input logic d);
    int word;
    expValid = 1'b0;
    expAbort = 1'b0;
    if (r) begin
      frameBits.delete();
      expOut = '0;
    end else if (s) begin
      frameBits.push_back(int'(d));
      if (frameBits.size() == WIDTH) begin
        word = 0;
        foreach (frameBits[i]) word += frameBits[i] * (2 ** i);
        expOut   = WIDTH'(word);
        expValid = 1'b1;
        frameBits.delete();
      end
    end else begin
      expAbort = (frameBits.size() != 0);
      frameBits.delete();
    end
    expCnt = CW'(frameBits.size());
  endtask

  // Compare all DUT outputs against the model.
  task automatic checkOutput(input string tag);
    tests++;
    assert (out === expOut) else begin
      failures++;
      $error("[TB] FAIL %s out: observed %h expected %h", tag, out, expOut);
    end
    tests++;
    assert (valid === expValid) else begin
      failures++;
      $error("[TB] FAIL %s valid: observed %b expected %b", tag, valid, expValid);
    end
    tests++;
    assert (abort === expAbort) else begin
      failures++;
      $error("[TB] FAIL %s abort: observed %b expected %b", tag, abort, expAbort);
    end
    tests++;
    assert (cnt === expCnt) else begin
      failures++;
      $error("[TB] FAIL %s cnt: observed %0d expected %0d", tag, cnt, expCnt);
    end
  endtask

  // Drive inputs on the falling edge, let one rising edge pass, then check
  // the outputs 1 unit after that edge.
  task automatic applyStimulus(input logic r, input logic s, input logic d,
                               input string tag);
    @(negedge clk);
    reset = r;
    sh    = s;
    sin   = d;
    @(posedge clk);
    modelStep(r, s, d);
    #1;
    checkOutput(tag);
  endtask

  // Transmitter side of the loopback. A load cycle (sh=0) is followed by
  // WIDTH shift cycles that carry the word LSB first.
  task automatic sendWord(input logic [WIDTH-1:0] word, input string tag);
    applyStimulus(1'b0, 1'b0, 1'($urandom), {tag, "_load"});
    for (int i = 0; i < WIDTH; i++)
      applyStimulus(1'b0, 1'b1, word[i], tag);
  endtask

  // Send bits LSB-first without any load cycle, used for back-to-back frames.
  task automatic shiftBits(input logic [WIDTH-1:0] word, input string tag);
    for (int i = 0; i < WIDTH; i++)
      applyStimulus(1'b0, 1'b1, word[i], tag);
  endtask

  initial begin
    reset = 1'b1;
    sh    = 1'b0;
    sin   = 1'b0;
    frameBits.delete();
    expOut   = '0;
    expValid = 1'b0;
    expAbort = 1'b0;
    expCnt   = '0;

    // Reset values.
    applyStimulus(1'b1, 1'b0, 1'b0, "reset0");
    applyStimulus(1'b1, 1'b1, 1'b1, "reset1");

    // First frame: bits 1,1,0,1 give 4'hB.
    applyStimulus(1'b0, 1'b1, 1'b1, "frameB_b1");
    applyStimulus(1'b0, 1'b1, 1'b1, "frameB_b2");
    applyStimulus(1'b0, 1'b1, 1'b0, "frameB_b3");
    applyStimulus(1'b0, 1'b1, 1'b1, "frameB_b4");
    applyStimulus(1'b0, 1'b0, 1'b0, "frameB_after");

    // Partial frame (1,0) cut off by sh=0. out holds 4'hB.
    applyStimulus(1'b0, 1'b1, 1'b1, "partial_b1");
    applyStimulus(1'b0, 1'b1, 1'b0, "partial_b2");
    applyStimulus(1'b0, 1'b0, 1'b1, "partial_abort");
    applyStimulus(1'b0, 1'b0, 1'b1, "partial_after");
    shiftBits(4'h3, "frame3");

    // Back-to-back frames 4'h5 then 4'hA with no gap cycle.
    shiftBits(4'h5, "b2b_5");
    shiftBits(4'hA, "b2b_A");
    applyStimulus(1'b0, 1'b0, 1'b0, "b2b_after");

    // Reset in the middle of a frame, then a 4'hF frame.
    applyStimulus(1'b0, 1'b1, 1'b1, "midreset_b1");
    applyStimulus(1'b0, 1'b1, 1'b0, "midreset_b2");
    applyStimulus(1'b0, 1'b1, 1'b1, "midreset_b3");
    applyStimulus(1'b1, 1'b1, 1'b1, "midreset_rst");
    shiftBits(4'hF, "frameF");

    // Idle with sin toggling. Nothing may change.
    for (int i = 0; i < 10; i++)
      applyStimulus(1'b0, 1'b0, 1'(i), "idle_toggle");

    // Loopback with a parallel-load transmitter: 4'h9, then random words.
    sendWord(4'h9, "loop_9");
    for (int i = 0; i < 120; i++)
      sendWord(WIDTH'($urandom), "loop_rand");

    // Random mix of shift, idle and occasional reset.
    for (int i = 0; i < 400; i++)
      applyStimulus(($urandom_range(0, 31) == 0),
                    ($urandom_range(0, 3) != 0),
                    1'($urandom), "random_mix");

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/sipo_rx.md
# sipo_rx

Serial-in, parallel-out receiver that reassembles WIDTH-bit words from an LSB-first serial bit stream. It is the receive end of the parallel-load/shift-out link. It samples one bit per enabled clock, tracks frame position with a bit counter, presents each completed word on a held parallel output with a one-cycle valid strobe, and flags frames cut short by deassertion of the shift enable.

## Interface
- WIDTH, 4, word width in bits; legal range 2..32.
- CW, $clog2(WIDTH), bit-counter width; derived, not overridden.

- clk  input  1  single clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high; sampled on the rising edge of clk.
- sh  input  1  shift enable; 1 = sample sin this edge, 0 = frame boundary/idle.
- sin  input  1  serial data, LSB of each word first.
- out  output  WIDTH  last completed word; held until the next completion.
- valid  output  1  one-cycle pulse; out was updated on this edge.
- abort  output  1  one-cycle pulse; a partial frame was discarded.
- cnt  output  CW  bits received in the current frame, 0..WIDTH-1.

## Operation
- Internal shift register sr[WIDTH-1:0]. Each sample shifts right and inserts at the MSB: sr <= {sin, sr[WIDTH-1:1]}. After WIDTH samples, the first bit received sits at bit 0.
- Two states:
  - IDLE: cnt == 0.
  - RECV: 0 < cnt < WIDTH.
- Edge with sh=1, cnt < WIDTH-1: shift sr; cnt <= cnt+1; enter or stay in RECV.
- Edge with sh=1, cnt == WIDTH-1 (completion): out <= {sin, sr[WIDTH-1:1]}; valid <= 1; cnt <= 0; sr <= 0; go to IDLE. Back-to-back frames are legal with no gap cycle, so the next edge with sh=1 starts a new frame.
- Edge with sh=0, cnt == 0: no change; valid=0, abort=0.
- Edge with sh=0, cnt != 0: partial frame discarded.
  - abort <= 1; cnt <= 0; sr <= 0.
  - out is unchanged and valid stays 0.
- valid and abort are never both 1 in the same cycle.
- reset=1 has priority over all other inputs:
  - out, sr and cnt are cleared to 0; valid and abort are 0.
  - A frame in progress is dropped silently; abort does not fire.
- sin is ignored when sh=0.

## Timing
- Reset values: out=0, valid=0, abort=0, cnt=0.
- sin is sampled on every rising edge where sh=1 and reset=0.
- Latency: out and valid are registered. Both change on the same edge that samples the WIDTH-th bit, and are visible for the following cycle.
- Throughput: one word per WIDTH enabled cycles; sustained at 100% with sh held high.
- cnt is a registered output. It reads k during the cycle after k bits have been sampled in the current frame.
- abort is asserted in the cycle after the sh=0 edge that discards the frame.
- Whenever a condition is absent, valid and abort return to 0 after exactly one cycle.
- Sender alignment: the sender drives word bit 0 on sin during the cycle after its load (sh=0). Each subsequent sh=1 edge both samples the current bit and advances the sender.

## Test plan
- Reset, then 4 edges with sh=1 and sin = 1,1,0,1 (WIDTH=4) -> after the 4th edge out=4'hB, valid=1 for exactly one cycle, cnt=0; cnt reads 1,2,3 after edges 1-3.
- Back-to-back frames: words 4'h5 then 4'hA sent with sh held high for 8 edges -> valid pulses after edge 4 (out=5) and edge 8 (out=A); no gap cycle and no abort.
- Partial frame: 2 bits (1,0), then sh=0 -> abort=1 for one cycle, cnt=0, out keeps its previous value (4'hB). A following full frame of 4'h3 then completes correctly.
- Reset mid-frame: after 3 bits, assert reset for one edge -> out=0, cnt=0, valid=0, abort=0. A subsequent 4'hF frame yields out=F.
- sh=0 idle with sin toggling for 10 cycles -> no change to out, cnt=0, no pulses.
- Loopback with the parallel-load shift transmitter (WIDTH=4): load 4'h9, then 4 sh=1 cycles -> out=9, valid pulse; repeat with random words (≥100) and compare every word.
